// File: rtl/program_load_sequencer.sv
// ============================================================================
// Module  : program_load_sequencer
// Purpose : Loads a byte program into instruction memory, then sequences the
//           4-stage core through run / halt / single-step / drain / done.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_load_sequencer #(
    parameter int IMEM_DEPTH = 32,
    parameter int ADDR_W     = 5,
    parameter int DRAIN_CYC  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              start,
    input  logic              halt_req,
    input  logic              step_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [7:0]        imem_wdata,
    output logic              core_reset,
    output logic              core_clk_en,
    output logic [ADDR_W:0]   prog_len,
    output logic              ovf,
    output logic              done,
    output logic [2:0]        state
);

    localparam int LEN_W   = ADDR_W + 1;
    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        HALT  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [LEN_W-1:0]     prog_len_q, prog_len_d;
    logic                 ovf_q, ovf_d;
    logic [LEN_W-1:0]     issue_q, issue_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic                 step_q, step_d;
    logic                 rerun_q, rerun_d;

    logic                 w_hs;
    logic                 w_issue;
    logic                 w_last_issue;
    logic [LEN_W-1:0]     w_issue_inc;
    logic [ADDR_W-1:0]    w_idx;

    // Outputs decode from registered state only, never from inputs.
    assign load_ready  = (state_q == IDLE) || (state_q == DONE);
    assign core_reset  = (state_q == IDLE) || (state_q == ARM);
    assign core_clk_en = (state_q == RUN) || (state_q == DRAIN) ||
                         ((state_q == HALT) && step_q);
    assign done        = (state_q == DONE);
    assign state       = state_q;
    assign imem_we     = we_q;
    assign imem_waddr  = waddr_q;
    assign imem_wdata  = wdata_q;
    assign prog_len    = prog_len_q;
    assign ovf         = ovf_q;

    assign w_hs         = load_valid && load_ready;
    assign w_issue      = core_clk_en && (state_q != DRAIN);
    assign w_issue_inc  = (&issue_q) ? issue_q : issue_q + LEN_W'(1);
    assign w_last_issue = w_issue && (w_issue_inc == prog_len_q);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        prog_len_d = prog_len_q;
        ovf_d      = ovf_q;
        issue_d    = issue_q;
        drain_d    = drain_q;
        step_d     = 1'b0;
        rerun_d    = rerun_q;
        w_idx      = idx_q;

        if (w_issue) begin
            issue_d = w_issue_inc;
        end

        // A byte accepted in DONE starts a fresh program at index 0.
        if (w_hs) begin
            if (state_q == DONE) begin
                w_idx      = '0;
                ovf_d      = 1'b0;
                prog_len_d = '0;
                state_d    = IDLE;
            end
            we_d    = 1'b1;
            waddr_d = w_idx;
            wdata_d = load_data;
            idx_d   = w_idx + ADDR_W'(1);
            if (load_last) begin
                prog_len_d = {1'b0, w_idx} + LEN_W'(1);
                idx_d      = '0;
                state_d    = ARM;
            end else if (w_idx == ADDR_W'(IMEM_DEPTH - 1)) begin
                ovf_d      = 1'b1;
                prog_len_d = LEN_W'(IMEM_DEPTH);
                idx_d      = '0;
                state_d    = ARM;
            end
        end

        case (state_q)
            IDLE: ;
            ARM: begin
                issue_d = '0;
                if (start || rerun_q) begin
                    state_d = RUN;
                    rerun_d = 1'b0;
                end
            end
            RUN: begin
                if (w_last_issue) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else if (halt_req) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (w_last_issue) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else if (step_req) begin
                    step_d = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN_CYC - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            DONE: begin
                // Rerun passes through ARM for one core_reset cycle.
                if (!w_hs && start) begin
                    state_d = ARM;
                    rerun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            prog_len_q <= '0;
            ovf_q      <= 1'b0;
            issue_q    <= '0;
            drain_q    <= '0;
            step_q     <= 1'b0;
            rerun_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            prog_len_q <= prog_len_d;
            ovf_q      <= ovf_d;
            issue_q    <= issue_d;
            drain_q    <= drain_d;
            step_q     <= step_d;
            rerun_q    <= rerun_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_program_load_sequencer.sv
// ============================================================================
// Module  : tb_program_load_sequencer
// Purpose : Directed self-checking bench for program_load_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_program_load_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       start;
    logic       halt_req;
    logic       step_req;
    logic       imem_we;
    logic [4:0] imem_waddr;
    logic [7:0] imem_wdata;
    logic       core_reset;
    logic       core_clk_en;
    logic [5:0] prog_len;
    logic       ovf;
    logic       done;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;

    program_load_sequencer #(
        .IMEM_DEPTH(32),
        .ADDR_W    (5),
        .DRAIN_CYC (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .start      (start),
        .halt_req   (halt_req),
        .step_req   (step_req),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .core_clk_en(core_clk_en),
        .prog_len   (prog_len),
        .ovf        (ovf),
        .done       (done),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Counts the enable seen in the cycle being closed by this edge.
    task automatic tick;
        if (core_clk_en === 1'b1) en_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
        start = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        apply_reset();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got=%0d want=0", state); end
        checks++; if (core_reset !== 1'b1 || core_clk_en !== 1'b0) begin errors++; $display("FAIL rst_core got rst=%b en=%b want 1 0", core_reset, core_clk_en); end
        checks++; if (load_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rst_ready_done got rdy=%b done=%b want 1 0", load_ready, done); end
        checks++; if (imem_we !== 1'b0 || imem_waddr !== 5'd0 || imem_wdata !== 8'h00) begin errors++; $display("FAIL rst_imem got we=%b a=%0d d=%h want 0 0 00", imem_we, imem_waddr, imem_wdata); end
        checks++; if (prog_len !== 6'd0 || ovf !== 1'b0) begin errors++; $display("FAIL rst_len got len=%0d ovf=%b want 0 0", prog_len, ovf); end
    endtask

    task automatic test_load3;
        load_valid = 1'b1; load_data = 8'h41; load_last = 1'b0;
        tick();
        checks++; if (imem_we !== 1'b1 || imem_waddr !== 5'd0 || imem_wdata !== 8'h41) begin errors++; $display("FAIL load_b0 got we=%b a=%0d d=%h want 1 0 41", imem_we, imem_waddr, imem_wdata); end
        load_data = 8'h52;
        tick();
        checks++; if (imem_we !== 1'b1 || imem_waddr !== 5'd1 || imem_wdata !== 8'h52) begin errors++; $display("FAIL load_b1 got we=%b a=%0d d=%h want 1 1 52", imem_we, imem_waddr, imem_wdata); end
        load_data = 8'h63; load_last = 1'b1;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        checks++; if (imem_we !== 1'b1 || imem_waddr !== 5'd2 || imem_wdata !== 8'h63) begin errors++; $display("FAIL load_b2 got we=%b a=%0d d=%h want 1 2 63", imem_we, imem_waddr, imem_wdata); end
        checks++; if (state !== 3'd1 || prog_len !== 6'd3 || ovf !== 1'b0) begin errors++; $display("FAIL load_arm got st=%0d len=%0d ovf=%b want 1 3 0", state, prog_len, ovf); end
        checks++; if (load_ready !== 1'b0 || core_reset !== 1'b1) begin errors++; $display("FAIL load_arm_out got rdy=%b crst=%b want 0 1", load_ready, core_reset); end
        tick();
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL load_we_pulse got we=%b want 0", imem_we); end
    endtask

    task automatic test_run3;
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        en_cnt = 0;
        checks++; if (state !== 3'd2 || core_reset !== 1'b0 || core_clk_en !== 1'b1) begin errors++; $display("FAIL run_enter got st=%0d crst=%b en=%b want 2 0 1", state, core_reset, core_clk_en); end
        wait_done(n);
        checks++; if (en_cnt !== 6 || n !== 6) begin errors++; $display("FAIL run_en_cycles got en=%0d cyc=%0d want 6 6", en_cnt, n); end
        checks++; if (done !== 1'b1 || state !== 3'd5 || core_clk_en !== 1'b0) begin errors++; $display("FAIL run_done got done=%b st=%0d en=%b want 1 5 0", done, state, core_clk_en); end
    endtask

    task automatic test_rerun;
        int n;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (state !== 3'd1 || core_reset !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rerun_arm got st=%0d crst=%b done=%b want 1 1 0", state, core_reset, done); end
        tick();
        en_cnt = 0;
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL rerun_run got st=%0d want 2", state); end
        wait_done(n);
        checks++; if (en_cnt !== 6 || done !== 1'b1) begin errors++; $display("FAIL rerun_cycles got en=%0d done=%b want 6 1", en_cnt, done); end
    endtask

    task automatic test_overflow;
        load_valid = 1'b1; load_last = 1'b0;
        for (int k = 0; k < 32; k++) begin
            load_data = 8'(8'h80 + k);
            tick();
            if (k == 0) begin
                checks++; if (state !== 3'd0 || ovf !== 1'b0 || prog_len !== 6'd0 || imem_waddr !== 5'd0 || imem_we !== 1'b1) begin errors++; $display("FAIL ovf_restart got st=%0d ovf=%b len=%0d a=%0d we=%b want 0 0 0 0 1", state, ovf, prog_len, imem_waddr, imem_we); end
            end
        end
        checks++; if (imem_we !== 1'b1 || imem_waddr !== 5'd31 || imem_wdata !== 8'h9F) begin errors++; $display("FAIL ovf_last_write got we=%b a=%0d d=%h want 1 31 9f", imem_we, imem_waddr, imem_wdata); end
        checks++; if (ovf !== 1'b1 || prog_len !== 6'd32 || state !== 3'd1 || load_ready !== 1'b0) begin errors++; $display("FAIL ovf_flags got ovf=%b len=%0d st=%0d rdy=%b want 1 32 1 0", ovf, prog_len, state, load_ready); end
        load_data = 8'hAA;
        tick();
        load_valid = 1'b0;
        checks++; if (imem_we !== 1'b0 || state !== 3'd1) begin errors++; $display("FAIL ovf_33rd got we=%b st=%0d want 0 1", imem_we, state); end
    endtask

    task automatic test_halt_step;
        int n;
        apply_reset();
        load_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            load_data = 8'(k + 1);
            load_last = (k == 4);
            tick();
        end
        load_valid = 1'b0; load_last = 1'b0;
        checks++; if (prog_len !== 6'd5 || state !== 3'd1) begin errors++; $display("FAIL hs_load got len=%0d st=%0d want 5 1", prog_len, state); end
        start = 1'b1; tick(); start = 1'b0;
        en_cnt = 0;
        tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        checks++; if (state !== 3'd3 || core_clk_en !== 1'b0) begin errors++; $display("FAIL hs_halt got st=%0d en=%b want 3 0", state, core_clk_en); end
        tick();
        checks++; if (core_clk_en !== 1'b0 || state !== 3'd3) begin errors++; $display("FAIL hs_hold got st=%0d en=%b want 3 0", state, core_clk_en); end
        step_req = 1'b1; tick(); step_req = 1'b0;
        checks++; if (core_clk_en !== 1'b1) begin errors++; $display("FAIL hs_step1 got en=%b want 1", core_clk_en); end
        tick();
        checks++; if (core_clk_en !== 1'b0 || state !== 3'd3) begin errors++; $display("FAIL hs_step1_end got st=%0d en=%b want 3 0", state, core_clk_en); end
        step_req = 1'b1; tick(); step_req = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (state !== 3'd2 || en_cnt !== 4) begin errors++; $display("FAIL hs_resume got st=%0d en=%0d want 2 4", state, en_cnt); end
        wait_done(n);
        checks++; if (en_cnt !== 8 || done !== 1'b1 || state !== 3'd5) begin errors++; $display("FAIL hs_total got en=%0d done=%b st=%0d want 8 1 5", en_cnt, done, state); end
    endtask

    task automatic test_halt_final;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        en_cnt = 0;
        repeat (4) tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        checks++; if (state !== 3'd4 || core_clk_en !== 1'b1) begin errors++; $display("FAIL hf_drain got st=%0d en=%b want 4 1", state, core_clk_en); end
        tick(); tick();
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL hf_drain_len got st=%0d want 4", state); end
        tick();
        checks++; if (state !== 3'd5 || done !== 1'b1 || en_cnt !== 8) begin errors++; $display("FAIL hf_done got st=%0d done=%b en=%0d want 5 1 8", state, done, en_cnt); end
    endtask

    task automatic test_reset_midrun;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL rm_running got st=%0d want 2", state); end
        #3 reset = 1'b1;
        #1;
        checks++; if (core_reset !== 1'b1 || core_clk_en !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL rm_async got crst=%b en=%b st=%0d want 1 0 0", core_reset, core_clk_en, state); end
        checks++; if (load_ready !== 1'b1 || prog_len !== 6'd0 || imem_we !== 1'b0) begin errors++; $display("FAIL rm_clear got rdy=%b len=%0d we=%b want 1 0 0", load_ready, prog_len, imem_we); end
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        checks++; if (state !== 3'd0 || imem_we !== 1'b0) begin errors++; $display("FAIL rm_after got st=%0d we=%b want 0 0", state, imem_we); end
    endtask

    initial begin
        test_reset();
        test_load3();
        test_run3();
        test_rerun();
        test_overflow();
        test_halt_step();
        test_halt_final();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
